// File: rtl/acc_cpu_gen2.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXEC/HALT with carry/zero flags and internal data memory.
// Optional CALL/RET link register is enabled with the ACC_CPU_CALLRET_EN macro.
module acc_cpu_gen2 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int PC_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W+3:0]   instruction,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [PC_W-1:0]     pc,
    output logic [DATA_W-1:0]   a,
    output logic                flag_z,
    output logic                flag_c,
    output logic                halted
);

    // Fetch handshake: an instruction is taken on a rising edge where
    // instr_valid && instr_ready; instr_ready is high only in FETCH.

    localparam int DEPTH = 1 << ADDR_W;
    localparam int MIN_W = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;

    localparam logic [3:0] OP_LDA  = 4'd0;
    localparam logic [3:0] OP_STA  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_JZ   = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_MOVI = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_ADC  = 4'd11;
    localparam logic [3:0] OP_JC   = 4'd12;
`ifdef ACC_CPU_CALLRET_EN
    localparam logic [3:0] OP_CALL = 4'd13;
    localparam logic [3:0] OP_RET  = 4'd14;
`endif
    localparam logic [3:0] OP_HLT  = 4'd15;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W+3:0]   ir;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W-1:0]   mem [DEPTH];
`ifdef ACC_CPU_CALLRET_EN
    logic [PC_W-1:0]     link;
`endif

    logic [3:0]          op;
    logic [ADDR_W-1:0]   x;
    logic [PC_W-1:0]     x_pc;
    logic [DATA_W-1:0]   x_data;
    logic [DATA_W:0]     sum_add;
    logic [DATA_W:0]     sum_adc;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                wr_a;
    logic                wr_c;

    assign op = ir[ADDR_W+3:ADDR_W];
    assign x  = ir[ADDR_W-1:0];

    always_comb begin
        x_pc = '0;
        x_pc[ADDR_W-1:0] = x;
        x_data = '0;
        x_data[MIN_W-1:0] = x[MIN_W-1:0];
    end

    // Carry is the top bit of the widened result; for SUB that bit is the borrow.
    assign sum_add = {1'b0, a} + {1'b0, opnd};
    assign sum_adc = {1'b0, a} + {1'b0, opnd} + {{DATA_W{1'b0}}, flag_c};
    assign diff    = {1'b0, a} - {1'b0, opnd};

    always_comb begin
        alu_res = a;
        alu_c   = flag_c;
        wr_a    = 1'b0;
        wr_c    = 1'b0;
        case (op)
            OP_LDA:  begin alu_res = opnd;       wr_a = 1'b1; end
            OP_AND:  begin alu_res = a & opnd;   wr_a = 1'b1; end
            OP_OR:   begin alu_res = a | opnd;   wr_a = 1'b1; end
            OP_XOR:  begin alu_res = a ^ opnd;   wr_a = 1'b1; end
            OP_MOVI: begin alu_res = x_data;     wr_a = 1'b1; end
            OP_ADD:  begin {alu_c, alu_res} = sum_add; wr_a = 1'b1; wr_c = 1'b1; end
            OP_SUB:  begin {alu_c, alu_res} = diff;    wr_a = 1'b1; wr_c = 1'b1; end
            OP_ADC:  begin {alu_c, alu_res} = sum_adc; wr_a = 1'b1; wr_c = 1'b1; end
            default: begin end
        endcase
    end

    // Store lands on the EXEC edge, so the next instruction's DECODE read sees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == S_EXEC && op == OP_STA) begin
            mem[x] <= a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= '0;
            a           <= '0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
            halted      <= 1'b0;
            instr_ready <= 1'b1;
            ir          <= '0;
            rd_addr     <= '0;
            opnd        <= '0;
`ifdef ACC_CPU_CALLRET_EN
            link        <= '0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir          <= instruction;
                        rd_addr     <= instruction[ADDR_W-1:0];
                        pc          <= pc + PC_W'(1);
                        instr_ready <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opnd  <= mem[rd_addr];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (wr_a) begin
                        a      <= alu_res;
                        flag_z <= (alu_res == '0);
                    end
                    if (wr_c) flag_c <= alu_c;
                    case (op)
                        OP_JZ:  if (flag_z) pc <= x_pc;
                        OP_JC:  if (flag_c) pc <= x_pc;
                        OP_JMP: pc <= x_pc;
`ifdef ACC_CPU_CALLRET_EN
                        OP_CALL: begin
                            link <= pc;
                            pc   <= x_pc;
                        end
                        OP_RET: pc <= link;
`endif
                        default: begin end
                    endcase
                    if (op == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        instr_ready <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu_gen2.sv
// Bench for acc_cpu_gen2: table-driven program with a scoreboard of expected architectural state.
// Expectations for CALL/RET follow the ACC_CPU_CALLRET_EN macro.
module tb_acc_cpu_gen2;

    logic        clk;
    logic        rst;
    logic [7:0]  instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  pc;
    logic [7:0]  a;
    logic        flag_z;
    logic        flag_c;
    logic        halted;

    int total;
    int bad;

    // Packed expectation: {a, z, c, pc, halted}
    logic [18:0] exp_q[$];

    typedef struct {
        logic [3:0] op;
        logic [3:0] x;
        logic [7:0] ea;
        logic       ez;
        logic       ec;
        logic [7:0] epc;
    } vec_t;

    vec_t tab1[6];
    vec_t tab2[21];

    acc_cpu_gen2 #(.DATA_W(8), .ADDR_W(4), .PC_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .a           (a),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual=running, required=done)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Runs one instruction through the 3-cycle handshake, then compares state.
    task automatic issue(input logic [3:0] op, input logic [3:0] x, input logic [7:0] ea,
                         input logic ez, input logic ec, input logic [7:0] epc, input logic eh);
        logic [18:0] e;
        exp_q.push_back({ea, ez, ec, epc, eh});
        check("ready_in_fetch", {31'd0, instr_ready}, 32'd1);
        instruction = {op, x};
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        check("ready_in_decode", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        check("ready_in_exec", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("a op%0d x%0d", op, x),  {24'd0, a},      {24'd0, e[18:11]});
            check($sformatf("z op%0d x%0d", op, x),  {31'd0, flag_z}, {31'd0, e[10]});
            check($sformatf("c op%0d x%0d", op, x),  {31'd0, flag_c}, {31'd0, e[9]});
            check($sformatf("pc op%0d x%0d", op, x), {24'd0, pc},     {24'd0, e[8:1]});
            check($sformatf("halted op%0d", op),     {31'd0, halted}, {31'd0, e[0]});
            check($sformatf("ready_after op%0d", op), {31'd0, instr_ready}, {31'd0, ~e[0]});
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},     {24'd0, pc},          32'd0);
        check({tag, "_a"},      {24'd0, a},           32'd0);
        check({tag, "_z"},      {31'd0, flag_z},      32'd0);
        check({tag, "_c"},      {31'd0, flag_c},      32'd0);
        check({tag, "_halted"}, {31'd0, halted},      32'd0);
        check({tag, "_ready"},  {31'd0, instr_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] acc;
        total = 0;
        bad = 0;

        tab1[0] = '{4'd8, 4'd5,  8'h05, 1'b0, 1'b0, 8'd1};
        tab1[1] = '{4'd1, 4'd3,  8'h05, 1'b0, 1'b0, 8'd2};
        tab1[2] = '{4'd8, 4'd0,  8'h00, 1'b1, 1'b0, 8'd3};
        tab1[3] = '{4'd0, 4'd3,  8'h05, 1'b0, 1'b0, 8'd4};
        tab1[4] = '{4'd8, 4'd15, 8'h0F, 1'b0, 1'b0, 8'd5};
        tab1[5] = '{4'd1, 4'd1,  8'h0F, 1'b0, 1'b0, 8'd6};

        tab2[0]  = '{4'd8,  4'd1,  8'h01, 1'b0, 1'b1, 8'd24};
        tab2[1]  = '{4'd1,  4'd2,  8'h01, 1'b0, 1'b1, 8'd25};
        tab2[2]  = '{4'd8,  4'd15, 8'h0F, 1'b0, 1'b1, 8'd26};
        tab2[3]  = '{4'd3,  4'd2,  8'h10, 1'b0, 1'b0, 8'd27};
        tab2[4]  = '{4'd8,  4'd0,  8'h00, 1'b1, 1'b0, 8'd28};
        tab2[5]  = '{4'd4,  4'd2,  8'hFF, 1'b0, 1'b1, 8'd29};
        tab2[6]  = '{4'd1,  4'd4,  8'hFF, 1'b0, 1'b1, 8'd30};
        tab2[7]  = '{4'd0,  4'd4,  8'hFF, 1'b0, 1'b1, 8'd31};
        tab2[8]  = '{4'd3,  4'd2,  8'h00, 1'b1, 1'b1, 8'd32};
        tab2[9]  = '{4'd11, 4'd0,  8'h01, 1'b0, 1'b0, 8'd33};
        tab2[10] = '{4'd8,  4'd3,  8'h03, 1'b0, 1'b0, 8'd34};
        tab2[11] = '{4'd4,  4'd3,  8'hFE, 1'b0, 1'b1, 8'd35};
        tab2[12] = '{4'd12, 4'd10, 8'hFE, 1'b0, 1'b1, 8'd10};
        tab2[13] = '{4'd5,  4'd2,  8'hFE, 1'b0, 1'b1, 8'd11};
        tab2[14] = '{4'd8,  4'd0,  8'h00, 1'b1, 1'b1, 8'd12};
        tab2[15] = '{4'd5,  4'd7,  8'h00, 1'b1, 1'b1, 8'd7};
        tab2[16] = '{4'd8,  4'd12, 8'h0C, 1'b0, 1'b1, 8'd8};
        tab2[17] = '{4'd2,  4'd3,  8'h04, 1'b0, 1'b1, 8'd9};
        tab2[18] = '{4'd9,  4'd1,  8'h0F, 1'b0, 1'b1, 8'd10};
        tab2[19] = '{4'd10, 4'd1,  8'h00, 1'b1, 1'b1, 8'd11};
        tab2[20] = '{4'd6,  4'd2,  8'h00, 1'b1, 1'b1, 8'd2};

        rst = 1'b1;
        instr_valid = 1'b0;
        instruction = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        foreach (tab1[i])
            issue(tab1[i].op, tab1[i].x, tab1[i].ea, tab1[i].ez, tab1[i].ec, tab1[i].epc, 1'b0);

        // ADD 1 with M[1]=0x0F walks 0x0F -> 0xFF without carry, then wraps with carry.
        acc = 8'h0F;
        for (int k = 1; k <= 16; k++) begin
            acc = acc + 8'h0F;
            issue(4'd3, 4'd1, acc, 1'b0, 1'b0, 8'(6 + k), 1'b0);
        end
        issue(4'd3, 4'd1, 8'h0E, 1'b0, 1'b1, 8'd23, 1'b0);

        foreach (tab2[i])
            issue(tab2[i].op, tab2[i].x, tab2[i].ea, tab2[i].ez, tab2[i].ec, tab2[i].epc, 1'b0);

        // Idle fetch: nothing may move while instr_valid is low.
        instruction = {4'd8, 4'd9};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_ready", {31'd0, instr_ready}, 32'd1);
            check("stall_pc", {24'd0, pc}, 32'd2);
            check("stall_a", {24'd0, a}, 32'd0);
        end

`ifdef ACC_CPU_CALLRET_EN
        issue(4'd13, 4'd9, 8'h00, 1'b1, 1'b1, 8'd9, 1'b0);
        issue(4'd14, 4'd0, 8'h00, 1'b1, 1'b1, 8'd3, 1'b0);
`else
        issue(4'd13, 4'd9, 8'h00, 1'b1, 1'b1, 8'd3, 1'b0);
        issue(4'd14, 4'd0, 8'h00, 1'b1, 1'b1, 8'd4, 1'b0);
`endif
        issue(4'd6, 4'd6, 8'h00, 1'b1, 1'b1, 8'd6, 1'b0);
        issue(4'd15, 4'd0, 8'h00, 1'b1, 1'b1, 8'd7, 1'b1);

        // Halted core ignores valid instructions.
        instruction = {4'd8, 4'd5};
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_ready", {31'd0, instr_ready}, 32'd0);
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_pc", {24'd0, pc}, 32'd7);
        end
        instr_valid = 1'b0;

        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("halt_reset");

        // Memory was cleared: M[3] held 5 before reset.
        issue(4'd0, 4'd3, 8'h00, 1'b1, 1'b0, 8'd1, 1'b0);
        issue(4'd8, 4'd9, 8'h09, 1'b0, 1'b0, 8'd2, 1'b0);

        // STA 5 aborted by reset while in EXEC.
        instruction = {4'd1, 4'd5};
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        check_reset_state("abort_reset");
        issue(4'd0, 4'd5, 8'h00, 1'b1, 1'b0, 8'd1, 1'b0);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_cpu_gen2.md
Name: acc_cpu_gen2

Overview:
- Parametrised multi-cycle accumulator CPU; successor to the 4-bit accumulator core.
- Data width is generic, and data memory is internal with synchronous read.
- Adds carry/zero flags, a valid/ready instruction-fetch handshake, and add-with-carry, jump-on-carry and halt instructions.
- Sits between the instruction ROM/sequencer (fetch port) and the debug/observation logic (accumulator, flags, halted).

Parameters:
- DATA_W, 8, accumulator and data-memory word width (>=2).
- ADDR_W, 4, operand field width; data memory depth is 2**ADDR_W.
- PC_W, 8, program counter width (>= ADDR_W).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- instruction  input  4+ADDR_W  opcode in [ADDR_W+3:ADDR_W], operand in [ADDR_W-1:0].
- instr_valid  input  1  instruction word valid for the current pc.
- instr_ready  output  1  core accepts an instruction this cycle.
- pc  output  PC_W  address of the next instruction to fetch.
- a  output  DATA_W  accumulator.
- flag_z  output  1  zero flag.
- flag_c  output  1  carry/borrow flag.
- halted  output  1  core stopped by HLT.

Behaviour:
- Reset (async, any state): state=FETCH; pc=0; a=0; flag_z=0; flag_c=0; halted=0; ir=0; all data-memory words=0.
- States:
  - FETCH: instr_ready=1. On instr_valid: ir<=instruction; mem read addr<=operand; pc<=pc+1 (wraps mod 2**PC_W); go to DECODE. Otherwise hold FETCH.
  - DECODE: memory read data is registered into opnd; go to EXEC.
  - EXEC: perform the opcode; go to FETCH, or to HALT for HLT.
  - HALT: instr_ready=0, halted=1; terminal until rst.
- instr_ready=0 in DECODE, EXEC and HALT. With instr_valid held high, one instruction takes 3 cycles.
- Opcodes (op = opcode, M = memory, X = operand zero-extended):
  - 0 LDA: a=M[X].
  - 1 STA: M[X]<=a (write at EXEC edge).
  - 2 AND: a=a&M.
  - 3 ADD: {c,a}=a+M.
  - 4 SUB: {c,a}=a-M; c=borrow (1 when a<M unsigned).
  - 5 JZ: pc=X if flag_z.
  - 6 JMP: pc=X.
  - 7 NOP.
  - 8 MOVI: a=X, truncated if ADDR_W>DATA_W.
  - 9 OR.
  - 10 XOR.
  - 11 ADC: {c,a}=a+M+flag_c.
  - 12 JC: pc=X if flag_c.
  - 13 CALL.
  - 14 RET.
  - 15 HLT.
- Flag rules:
  - flag_z <= (new a==0) on every opcode that writes a (0,2,3,4,8,9,10,11,13/14 excluded).
  - flag_c is written only by ADD/SUB/ADC.
  - Other opcodes leave both flags unchanged.
- Jumps: taken in EXEC and override the FETCH increment. The next fetch uses the target.
- Arithmetic is modulo 2**DATA_W. Carry is bit DATA_W of the (DATA_W+1)-bit result.
- STA followed by LDA of the same address returns the new value (write completes before the next read issue).
- rst asserted mid-instruction aborts it. A pending STA does not write.

Optional Feature:
- Macro ACC_CPU_CALLRET_EN.
- Defined:
  - CALL: link<=pc (the already-incremented return address), then pc=X.
  - RET: pc=link.
  - link is a single PC_W register, reset to 0. A nested CALL overwrites it.
- Undefined: no link register; opcodes 13/14 execute as NOP (no state or flag change).

Test Plan:
- Reset then MOVI 5, STA 3, MOVI 0, LDA 3 -> a=5, flag_z=0, M[3]=5; pc=4 after the 4th EXEC.
- MOVI 15 (a=0x0F), STA 1, repeat ADD 1 until carry; with a=0xF0, ADD 1 -> a=0xFF, c=0. Then MOVI 1, STA 2, MOVI 15, ADD 2 -> a=0x10, c=0. Then load 0xFF via LDA and ADD a cell holding 1 -> a=0x00, c=1, z=1. Then ADC with operand 0 -> a=0x01, c=0.
- SUB: a=3, M=5 -> a=0xFE, c=1. JC 10 -> pc=10. JZ 2 with z=0 -> not taken, pc increments.
- Fetch handshake: instr_valid low 4 cycles in FETCH -> pc, a and ir frozen, instr_ready held 1. Valid asserted -> accepted in one cycle, instr_ready low for the next 2 cycles.
- HLT at pc=6 -> halted=1, instr_ready=0 indefinitely. rst pulse mid-HALT -> all outputs return to reset values.
- With ACC_CPU_CALLRET_EN: CALL 9 at pc=2 -> pc=9; RET -> pc=3. Without it: same program -> pc=3, then pc=4, no jump.
